pwm_capture_register: RTL

Bus-addressable PWM input capture block: the measuring counterpart of the PWM output register. It samples an external PWM signal, measures its high time and period in prescaled clock ticks, and lets the host read both results over the same 8-bit address/data bus used by the output-side registers. It sits on the expander's register bus next to the PWM output channels, at its own address window.

---
 rtl/pwm_capture_pkg.sv | 32 +++
 rtl/pwm_edge_detector.sv | 67 ++++++
 rtl/pwm_capture_register.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_pkg.sv
// -----------------------------------------------------------------------------
// pwm_capture_pkg
// Shared definitions for the PWM input capture block: register offsets inside
// the 7-byte bus window, status bit positions and the measurement FSM states.
// -----------------------------------------------------------------------------
package pwm_capture_pkg;

    // Number of bytes in the register window.
    localparam int NUM_REGS = 7;

    // Register offsets relative to StartAddress.
    localparam logic [2:0] OFS_HIGH_U  = 3'd0;
    localparam logic [2:0] OFS_HIGH_L  = 3'd1;
    localparam logic [2:0] OFS_PER_U   = 3'd2;
    localparam logic [2:0] OFS_PER_L   = 3'd3;
    localparam logic [2:0] OFS_PRESC_U = 3'd4;
    localparam logic [2:0] OFS_PRESC_L = 3'd5;
    localparam logic [2:0] OFS_STATUS  = 3'd6;

    // Bit positions inside the status register.
    localparam int STAT_VALID    = 0;
    localparam int STAT_OVERFLOW = 1;
    localparam int STAT_LEVEL    = 2;

    // Measurement FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } captureState_t;

endpackage

// File: rtl/pwm_edge_detector.sv
// -----------------------------------------------------------------------------
// pwm_edge_detector
// Brings the asynchronous PWM pin into the CLK domain and produces one-cycle
// rise/fall pulses plus the clean level.
//
// Ports:
//   CLK    in   system clock
//   RST    in   synchronous active-high reset
//   PWMIn  in   asynchronous PWM pin
//   level  out  synchronized (optionally filtered) pin level
//   rise   out  one-cycle pulse on a detected rising edge
//   fall   out  one-cycle pulse on a detected falling edge
//
// Build option: define PWM_CAPTURE_GLITCH_FILTER_EN to insert a 3-sample
// majority filter after the synchronizer (adds 1 CLK of edge latency and
// rejects pulses of 1 CLK or shorter).
// -----------------------------------------------------------------------------
module pwm_edge_detector (
    input  logic CLK,
    input  logic RST,
    input  logic PWMIn,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] syncFf;    // syncFf[1] is the metastability-safe sample
    logic       prevLevel;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // Two older samples of the synchronized pin; the level follows the
    // majority of the current sample and these two, so a single-cycle
    // excursion never wins the vote.
    logic [1:0] history;

    always_ff @(posedge CLK) begin
        if (RST) begin
            history <= 2'b00;
        end else begin
            history <= {history[0], syncFf[1]};
        end
    end

    assign level = (syncFf[1] & history[0]) |
                   (syncFf[1] & history[1]) |
                   (history[0] & history[1]);
`else
    assign level = syncFf[1];
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop in the
    // chain samples the value from before this edge; blocking here would
    // collapse the synchronizer into a single stage.
    always_ff @(posedge CLK) begin
        if (RST) begin
            syncFf    <= 2'b00;
            prevLevel <= 1'b0;
        end else begin
            syncFf    <= {syncFf[0], PWMIn};
            prevLevel <= level;
        end
    end

    assign rise = level & ~prevLevel;
    assign fall = ~level & prevLevel;

endmodule

// File: rtl/pwm_capture_register.sv
// -----------------------------------------------------------------------------
// pwm_capture_register
// Bus-addressable PWM input capture. Measures high time and period of PWMIn in
// prescaled ticks and exposes them through a 7-byte register window.
//
// Parameters:
//   StartAddress  base address of the register window
//   AddressWidth  width of AddressBus
// Ports:
//   CLK           system clock
//   RST           synchronous active-high reset
//   _Write        active-low write strobe (acts on its falling edge)
//   _Read         active-low read strobe (acts on its falling edge)
//   AddressBus    register address
//   DataIn        write data
//   DataOut       registered read data
//   PWMIn         asynchronous PWM input pin
//   CaptureValid  mirror of the status Valid bit
//
// Build option: PWM_CAPTURE_GLITCH_FILTER_EN (see pwm_edge_detector).
// -----------------------------------------------------------------------------
module pwm_capture_register
    import pwm_capture_pkg::*;
#(
    parameter int StartAddress = 0,
    parameter int AddressWidth = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    _Write,
    input  logic                    _Read,
    input  logic [AddressWidth-1:0] AddressBus,
    input  logic [7:0]              DataIn,
    output logic [7:0]              DataOut,
    input  logic                    PWMIn,
    output logic                    CaptureValid
);

    logic pwmLevel;
    logic pwmRise;
    logic pwmFall;

    pwm_edge_detector edgeDetector (
        .CLK   (CLK),
        .RST   (RST),
        .PWMIn (PWMIn),
        .level (pwmLevel),
        .rise  (pwmRise),
        .fall  (pwmFall)
    );

    // ---------------- bus decode ----------------
    logic                    writePrev;
    logic                    readPrev;
    logic [AddressWidth-1:0] offset;
    logic                    inWindow;
    logic [2:0]              regSel;
    logic                    writeHit;
    logic                    readHit;
    logic                    prescWrite;
    logic                    statusRead;

    // Addresses below StartAddress wrap to large offsets and fall out of range.
    assign offset     = AddressBus - AddressWidth'(StartAddress);
    assign inWindow   = (offset < AddressWidth'(NUM_REGS));
    assign regSel     = offset[2:0];
    assign writeHit   = ~_Write & writePrev & inWindow;
    assign readHit    = ~_Read & readPrev & inWindow;
    assign prescWrite = writeHit & ((regSel == OFS_PRESC_U) | (regSel == OFS_PRESC_L));
    assign statusRead = readHit & (regSel == OFS_STATUS);

    // ---------------- measurement state ----------------
    captureState_t state;
    logic [15:0]   prescaler;
    logic [15:0]   presCnt;
    logic [15:0]   highCnt;
    logic [15:0]   perCnt;
    logic [15:0]   highTime;
    logic [15:0]   period;
    logic [15:0]   snapPeriod;
    logic [7:0]    snapHighLo;
    logic          valid;
    logic          overflow;
    logic          tick;
    logic          periodFull;
    logic [7:0]    statusByte;
    logic [7:0]    readData;

    assign tick         = (presCnt == prescaler);
    assign periodFull   = (perCnt == 16'hFFFF);
    assign CaptureValid = valid;

    // NOTE: every variable driven in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        statusByte                = 8'h00;
        statusByte[STAT_VALID]    = valid;
        statusByte[STAT_OVERFLOW] = overflow;
        statusByte[STAT_LEVEL]    = pwmLevel;
    end

    always_comb begin
        readData = 8'h00;
        case (regSel)
            OFS_HIGH_U:  readData = highTime[15:8];
            OFS_HIGH_L:  readData = snapHighLo;
            OFS_PER_U:   readData = snapPeriod[15:8];
            OFS_PER_L:   readData = snapPeriod[7:0];
            OFS_PRESC_U: readData = prescaler[15:8];
            OFS_PRESC_L: readData = prescaler[7:0];
            OFS_STATUS:  readData = statusByte;
            default:     readData = 8'h00;
        endcase
    end

    // ---------------- register file / bus side ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            writePrev  <= 1'b1;
            readPrev   <= 1'b1;
            DataOut    <= 8'h00;
            prescaler  <= 16'h0000;
            snapHighLo <= 8'h00;
            snapPeriod <= 16'h0000;
        end else begin
            writePrev <= _Write;
            readPrev  <= _Read;

            if (writeHit) begin
                if (regSel == OFS_PRESC_U) prescaler[15:8] <= DataIn;
                if (regSel == OFS_PRESC_L) prescaler[7:0]  <= DataIn;
            end

            if (readHit) begin
                DataOut <= readData;
                // Reading the upper HighTime byte freezes the remaining result
                // bytes so a multi-byte read sees one consistent capture.
                if (regSel == OFS_HIGH_U) begin
                    snapHighLo <= highTime[7:0];
                    snapPeriod <= period;
                end
            end
        end
    end

    // ---------------- prescaler and measurement FSM ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            presCnt  <= 16'h0000;
            highCnt  <= 16'h0000;
            perCnt   <= 16'h0000;
            highTime <= 16'h0000;
            period   <= 16'h0000;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            // Ticks are phase-aligned to each rising edge of the input.
            if (prescWrite || pwmRise || tick) presCnt <= 16'h0000;
            else                               presCnt <= presCnt + 16'd1;

            // Read-to-clear comes first so a capture or overflow on the same
            // cycle overrides it below.
            if (statusRead) begin
                valid    <= 1'b0;
                overflow <= 1'b0;
            end

            if (prescWrite) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (pwmRise) begin
                            highCnt <= 16'h0000;
                            perCnt  <= 16'h0000;
                            state   <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (tick && periodFull) begin
                            overflow <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            if (tick) begin
                                highCnt <= highCnt + 16'd1;
                                perCnt  <= perCnt + 16'd1;
                            end
                            if (pwmFall) state <= LOW;
                        end
                    end
                    LOW: begin
                        if (tick && periodFull) begin
                            overflow <= 1'b1;
                            state    <= IDLE;
                        end else if (pwmRise) begin
                            // A tick on the edge cycle still belongs to the
                            // period that is closing.
                            highTime <= highCnt;
                            period   <= perCnt + {15'd0, tick};
                            valid    <= 1'b1;
                            highCnt  <= 16'h0000;
                            perCnt   <= 16'h0000;
                            state    <= HIGH;
                        end else if (tick) begin
                            perCnt <= perCnt + 16'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
